// File: rtl/snake_engine.sv
// Snake game core: direction capture, body shift register, collision/food logic and a pixel lookup.
// Game state advances on tick; snake_on/head_on lag pix_x/pix_y by exactly 2 clk.
module snake_engine #(
    parameter int GRID_W  = 32,
    parameter int GRID_H  = 24,
    parameter int CELL_PX = 20,
    parameter int MAX_LEN = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       up,
    input  logic       down,
    input  logic       left,
    input  logic       right,
    input  logic       tick,
    input  logic [4:0] food_x,
    input  logic [4:0] food_y,
    input  logic [9:0] pix_x,
    input  logic [9:0] pix_y,
    output logic       snake_on,
    output logic       head_on,
    output logic       eaten,
    output logic       game_over,
    output logic [4:0] length
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DEAD} state_t;
    // Encoding keeps opposite directions one bit apart (d ^ 1).
    typedef enum logic [1:0] {D_UP, D_DOWN, D_LEFT, D_RIGHT} dir_t;

    state_t     state_q, state_d;
    dir_t       cur_q, cur_d;
    dir_t       pend_q, pend_d;
    dir_t       btn_dir;
    logic [4:0] len_q, len_d;
    logic       eaten_q, eaten_d;
    logic       shift_en;
    logic [4:0] seg_x_q [MAX_LEN];
    logic [4:0] seg_y_q [MAX_LEN];
    logic [4:0] nxt_x, nxt_y;
    logic       wall, eat, self_hit;

    logic [4:0] cell_x_d, cell_y_d, cell_x_q, cell_y_q;
    logic       vis_d, vis_q;
    logic       snake_on_d, head_on_d, snake_on_q, head_on_q;

    always_comb begin
        btn_dir = D_RIGHT;
        if (up)         btn_dir = D_UP;
        else if (down)  btn_dir = D_DOWN;
        else if (left)  btn_dir = D_LEFT;
        pend_d = pend_q;
        if (state_q == S_RUN && (up | down | left | right) &&
            btn_dir != dir_t'(cur_q ^ 2'b01))
            pend_d = btn_dir;
    end

    // A tick moves using this clk's freshest pending direction.
    always_comb begin
        nxt_x = seg_x_q[0];
        nxt_y = seg_y_q[0];
        wall  = 1'b0;
        case (pend_d)
            D_UP:    if (seg_y_q[0] == 5'd0) wall = 1'b1; else nxt_y = seg_y_q[0] - 5'd1;
            D_DOWN:  if (seg_y_q[0] == 5'(GRID_H - 1)) wall = 1'b1; else nxt_y = seg_y_q[0] + 5'd1;
            D_LEFT:  if (seg_x_q[0] == 5'd0) wall = 1'b1; else nxt_x = seg_x_q[0] - 5'd1;
            default: if (seg_x_q[0] == 5'(GRID_W - 1)) wall = 1'b1; else nxt_x = seg_x_q[0] + 5'd1;
        endcase
        eat      = (nxt_x == food_x) && (nxt_y == food_y);
        self_hit = 1'b0;
        // The tail cell vacates on this step unless the snake grows.
        for (int i = 0; i < MAX_LEN; i++)
            if (i < int'(len_q) - (eat ? 0 : 1) && seg_x_q[i] == nxt_x && seg_y_q[i] == nxt_y)
                self_hit = 1'b1;
    end

    always_comb begin
        state_d  = state_q;
        cur_d    = cur_q;
        len_d    = len_q;
        eaten_d  = 1'b0;
        shift_en = 1'b0;
        case (state_q)
            S_IDLE: if (up | down | right) state_d = S_RUN;
            S_RUN: begin
                if (tick) begin
                    if (wall || self_hit) begin
                        state_d = S_DEAD;
                    end else begin
                        shift_en = 1'b1;
                        cur_d    = pend_d;
                        eaten_d  = eat;
                        if (eat && len_q < 5'(MAX_LEN)) len_d = len_q + 5'd1;
                    end
                end
            end
            S_DEAD:  state_d = S_DEAD;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cur_q   <= D_RIGHT;
            pend_q  <= D_RIGHT;
            len_q   <= 5'd3;
            eaten_q <= 1'b0;
            for (int i = 0; i < MAX_LEN; i++) begin
                seg_x_q[i] <= (i < 3) ? 5'(GRID_W / 2 - i) : 5'd0;
                seg_y_q[i] <= (i < 3) ? 5'(GRID_H / 2) : 5'd0;
            end
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            pend_q  <= pend_d;
            len_q   <= len_d;
            eaten_q <= eaten_d;
            if (shift_en) begin
                seg_x_q[0] <= nxt_x;
                seg_y_q[0] <= nxt_y;
                for (int i = 1; i < MAX_LEN; i++) begin
                    seg_x_q[i] <= seg_x_q[i-1];
                    seg_y_q[i] <= seg_y_q[i-1];
                end
            end
        end
    end

    // Cell index = number of cell boundaries at or left of the pixel.
    always_comb begin
        cell_x_d = 5'd0;
        cell_y_d = 5'd0;
        for (int k = 1; k < GRID_W; k++)
            if (pix_x >= 10'(k * CELL_PX)) cell_x_d = cell_x_d + 5'd1;
        for (int k = 1; k < GRID_H; k++)
            if (pix_y >= 10'(k * CELL_PX)) cell_y_d = cell_y_d + 5'd1;
        vis_d = (pix_x < 10'(GRID_W * CELL_PX)) && (pix_y < 10'(GRID_H * CELL_PX));
    end

    always_comb begin
        snake_on_d = 1'b0;
        for (int i = 0; i < MAX_LEN; i++)
            if (i < int'(len_q) && seg_x_q[i] == cell_x_q && seg_y_q[i] == cell_y_q)
                snake_on_d = vis_q;
        head_on_d = vis_q && seg_x_q[0] == cell_x_q && seg_y_q[0] == cell_y_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cell_x_q   <= 5'd0;
            cell_y_q   <= 5'd0;
            vis_q      <= 1'b0;
            snake_on_q <= 1'b0;
            head_on_q  <= 1'b0;
        end else begin
            cell_x_q   <= cell_x_d;
            cell_y_q   <= cell_y_d;
            vis_q      <= vis_d;
            snake_on_q <= snake_on_d;
            head_on_q  <= head_on_d;
        end
    end

    assign snake_on  = snake_on_q;
    assign head_on   = head_on_q;
    assign eaten     = eaten_q;
    assign game_over = (state_q == S_DEAD);
    assign length    = len_q;

endmodule

// File: tb/tb_snake_engine.sv
// Bench for snake_engine: directed game scenarios plus randomized play against a queue-based model.
module tb_snake_engine;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       up = 1'b0, down = 1'b0, left = 1'b0, right = 1'b0, tick = 1'b0;
    logic [4:0] food_x = 5'd0, food_y = 5'd23;
    logic [9:0] pix_x = 10'd0, pix_y = 10'd0;
    logic       snake_on, head_on, eaten, game_over;
    logic [4:0] length;

    snake_engine dut (
        .clk(clk), .reset(reset),
        .up(up), .down(down), .left(left), .right(right),
        .tick(tick), .food_x(food_x), .food_y(food_y),
        .pix_x(pix_x), .pix_y(pix_y),
        .snake_on(snake_on), .head_on(head_on),
        .eaten(eaten), .game_over(game_over), .length(length)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    endtask

    // Model: body as a list of cells, head first; directions 0 up, 1 down, 2 left, 3 right.
    typedef struct {int x; int y;} cell_t;
    cell_t body[$];
    int m_state;
    int m_cur, m_pend;
    int m_eaten;
    int exp_snake, exp_head, nxt_snake, nxt_head;

    function automatic int dx(input int d);
        return (d == 2) ? -1 : (d == 3) ? 1 : 0;
    endfunction
    function automatic int dy(input int d);
        return (d == 0) ? -1 : (d == 1) ? 1 : 0;
    endfunction
    function automatic bit opposite(input int a, input int b);
        return (dx(a) + dx(b) == 0) && (dy(a) + dy(b) == 0);
    endfunction

    task automatic model_reset();
        cell_t c;
        body.delete();
        for (int i = 0; i < 3; i++) begin
            c.x = 16 - i; c.y = 12;
            body.push_back(c);
        end
        m_state = 0; m_cur = 3; m_pend = 3; m_eaten = 0;
        exp_snake = 0; exp_head = 0; nxt_snake = 0; nxt_head = 0;
    endtask

    task automatic model_edge();
        int cand, lim;
        bit hit, eat;
        cell_t nh;
        m_eaten = 0;
        if (m_state == 0) begin
            if (up || down || right) m_state = 1;
        end else if (m_state == 1) begin
            cand = up ? 0 : down ? 1 : left ? 2 : right ? 3 : -1;
            if (cand >= 0 && !opposite(cand, m_cur)) m_pend = cand;
            if (tick) begin
                nh.x = body[0].x + dx(m_pend);
                nh.y = body[0].y + dy(m_pend);
                eat  = (nh.x == int'(food_x)) && (nh.y == int'(food_y));
                hit  = nh.x < 0 || nh.x > 31 || nh.y < 0 || nh.y > 23;
                lim  = eat ? body.size() : body.size() - 1;
                for (int i = 0; i < lim; i++)
                    if (body[i].x == nh.x && body[i].y == nh.y) hit = 1;
                if (hit) begin
                    m_state = 2;
                end else begin
                    body.push_front(nh);
                    if (!eat || body.size() > 16) void'(body.pop_back());
                    m_eaten = eat;
                    m_cur = m_pend;
                end
            end
        end
        exp_snake = nxt_snake;
        exp_head  = nxt_head;
        nxt_snake = 0;
        nxt_head  = 0;
        if (pix_x < 640 && pix_y < 480) begin
            for (int i = 0; i < body.size(); i++)
                if (body[i].x == int'(pix_x) / 20 && body[i].y == int'(pix_y) / 20) begin
                    nxt_snake = 1;
                    if (i == 0) nxt_head = 1;
                end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        chk("length", length, body.size());
        chk("game_over", game_over, int'(m_state == 2));
        chk("eaten", eaten, m_eaten);
        chk("snake_on", snake_on, exp_snake);
        chk("head_on", head_on, exp_head);
    endtask

    task automatic press(input int d);
        up = (d == 0); down = (d == 1); left = (d == 2); right = (d == 3);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #1;
        model_reset();
        chk("rst_length", length, 3);
        chk("rst_game_over", game_over, 0);
        chk("rst_eaten", eaten, 0);
        chk("rst_snake_on", snake_on, 0);
        chk("rst_head_on", head_on, 0);
        press(-1);
        tick = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic do_tick();
        tick = 1'b1;
        step();
        tick = 1'b0;
    endtask

    task automatic move(input int d);
        press(d);
        step();
        do_tick();
        press(-1);
    endtask

    task automatic probe(input int cx, input int cy);
        pix_x = 10'(cx * 20 + 10);
        pix_y = 10'(cy * 20 + 10);
        step();
        step();
    endtask

    initial begin
        #2;
        do_reset();

        // Right held, three ticks.
        food_x = 5'd0; food_y = 5'd23;
        press(3);
        step();
        for (int t = 0; t < 3; t++) begin
            do_tick();
            step();
        end
        probe(19, 12);
        chk("run3_head_19_12", head_on, 1);
        chk("run3_length", length, 3);
        chk("run3_game_over", game_over, 0);

        // Reverse press is ignored.
        press(2);
        step();
        do_tick();
        press(-1);
        probe(20, 12);
        chk("reverse_ignored_head", head_on, 1);

        // Eat at (17,12).
        do_reset();
        food_x = 5'd17; food_y = 5'd12;
        press(3);
        step();
        press(-1);
        do_tick();
        chk("eat_pulse", eaten, 1);
        step();
        chk("eat_pulse_width", eaten, 0);
        chk("eat_length", length, 4);
        food_x = 5'd0; food_y = 5'd23;
        probe(14, 12);
        chk("eat_tail_kept", snake_on, 1);

        // Straight up into the top wall.
        do_reset();
        press(0);
        step();
        for (int t = 0; t < 12; t++) do_tick();
        chk("wall_alive_at_y0", game_over, 0);
        do_tick();
        chk("wall_dead", game_over, 1);
        chk("wall_eaten", eaten, 0);
        press(3);
        for (int t = 0; t < 3; t++) do_tick();
        press(-1);
        probe(16, 0);
        chk("wall_head_frozen", head_on, 1);
        chk("wall_still_dead", game_over, 1);

        // Pixel pipeline latency and off-screen blanking.
        do_reset();
        pix_x = 10'd330; pix_y = 10'd245;
        step();
        chk("pix_lat1_head", head_on, 0);
        step();
        chk("pix_lat2_head", head_on, 1);
        chk("pix_lat2_snake", snake_on, 1);
        pix_x = 10'd700; pix_y = 10'd10;
        step();
        step();
        chk("pix_offscreen_head", head_on, 0);
        chk("pix_offscreen_snake", snake_on, 0);

        // Length 5 tight loop into the body.
        do_reset();
        food_x = 5'd17; food_y = 5'd12;
        press(3);
        step();
        press(-1);
        do_tick();
        food_x = 5'd18;
        do_tick();
        food_x = 5'd0; food_y = 5'd23;
        chk("loop_length5", length, 5);
        move(0);
        move(2);
        chk("loop_alive", game_over, 0);
        move(1);
        chk("loop_self_dead", game_over, 1);
        chk("loop_frozen_len", length, 5);

        // Length 4 loop into the vacating tail cell.
        do_reset();
        food_x = 5'd17; food_y = 5'd12;
        press(3);
        step();
        press(-1);
        do_tick();
        food_x = 5'd0; food_y = 5'd23;
        move(0);
        move(2);
        move(1);
        chk("tail_chase_alive", game_over, 0);
        probe(16, 12);
        chk("tail_chase_head", head_on, 1);

        // Randomized play.
        for (int g = 0; g < 25; g++) begin
            do_reset();
            for (int c = 0; c < 300; c++) begin
                up    = ($urandom_range(0, 5) == 0);
                down  = ($urandom_range(0, 5) == 0);
                left  = ($urandom_range(0, 5) == 0);
                right = ($urandom_range(0, 5) == 0);
                tick  = ($urandom_range(0, 3) == 0);
                if ($urandom_range(0, 2) == 0 &&
                    body[0].x + dx(m_pend) >= 0 && body[0].x + dx(m_pend) <= 31 &&
                    body[0].y + dy(m_pend) >= 0 && body[0].y + dy(m_pend) <= 23) begin
                    food_x = 5'(body[0].x + dx(m_pend));
                    food_y = 5'(body[0].y + dy(m_pend));
                end else begin
                    food_x = 5'($urandom_range(0, 31));
                    food_y = 5'($urandom_range(0, 23));
                end
                if ($urandom_range(0, 1) == 0) begin
                    int idx;
                    idx   = $urandom_range(0, body.size() - 1);
                    pix_x = 10'(body[idx].x * 20 + $urandom_range(0, 19));
                    pix_y = 10'(body[idx].y * 20 + $urandom_range(0, 19));
                end else begin
                    pix_x = 10'($urandom_range(0, 799));
                    pix_y = 10'($urandom_range(0, 524));
                end
                step();
                if (c == 150 && g % 5 == 4) do_reset();
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/snake_engine.md
SNAKE_ENGINE -- requirements
Module: snake_engine

Interface
REQ-001 SHALL have parameter GRID_W, 32, playfield width in cells.
REQ-002 SHALL have parameter GRID_H, 24, playfield height in cells.
REQ-003 SHALL have parameter CELL_PX, 20, cell edge in pixels; 640x480 visible area.
REQ-004 SHALL have parameter MAX_LEN, 16, maximum segment count.
REQ-005 SHALL have port clk  in  1  single clock for all logic.
REQ-006 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-007 SHALL have ports up, down, left, right  in  1 each  direction buttons, already synchronised, level-sensitive.
REQ-008 SHALL have port tick  in  1  game-step strobe, one clk wide.
REQ-009 SHALL have ports food_x  in  5 and food_y  in  5  food cell coordinates.
REQ-010 SHALL have ports pix_x  in  10 and pix_y  in  10  current pixel from the VGA controller.
REQ-011 SHALL have port snake_on  out  1  pixel lies in a body cell.
REQ-012 SHALL have port head_on  out  1  pixel lies in the head cell.
REQ-013 SHALL have port eaten  out  1  one-clk pulse on a food hit.
REQ-014 SHALL have port game_over  out  1  DEAD state indicator.
REQ-015 SHALL have port length  out  5  current segment count.

Function
REQ-016 SHALL hold segment registers seg[0..MAX_LEN-1] as 5-bit x and 5-bit y; seg[0] is the head; only seg[0..length-1] are active.
REQ-017 SHALL implement FSM IDLE, RUN, DEAD.
- IDLE->RUN: first clk with up, down or right high.
- RUN->DEAD: collision on a tick.
- DEAD: held until reset.
REQ-018 SHALL sample buttons every clk into pending direction.
- Priority: up > down > left > right.
- A press opposite the current direction is ignored.
- Pending direction is applied only on tick.
REQ-019 SHALL, on tick in RUN, compute next head = seg[0] plus one cell in pending direction; y increases downward.
REQ-020 SHALL detect wall collision when next head x < 0 or > GRID_W-1, or y < 0 or > GRID_H-1; no wrap-around.
REQ-021 SHALL detect self collision when next head equals any seg[i] with i < length-1, or i < length when the same tick eats.
REQ-022 SHALL, on collision, enter DEAD with segments and length frozen and no eaten pulse.
REQ-023 SHALL, on a non-colliding tick, shift seg[i] <= seg[i-1] for all i and load seg[0] with next head.
REQ-024 SHALL, when next head equals (food_x, food_y), pulse eaten the clk after the tick and increment length, saturating at MAX_LEN; at MAX_LEN eaten still pulses.
REQ-025 SHALL ignore tick in IDLE and DEAD.
REQ-026 SHALL ignore tick and buttons arriving in the same clk as the IDLE->RUN transition; movement starts on the next tick.
REQ-027 SHALL derive cell_x = pix_x / CELL_PX and cell_y = pix_y / CELL_PX without a combinational divider, using a comparator or subtract chain, registered.
REQ-028 SHALL register snake_on and head_on with a fixed 2-clk latency from pix_x/pix_y.
REQ-029 SHALL force snake_on and head_on to 0 for pix_x >= 640 or pix_y >= 480.
REQ-030 SHALL compute pixel lookup from the segment state visible at the pixel's sample clk; a tick update in between is not glitch-masked.
REQ-031 SHALL assert snake_on whenever head_on is asserted.

Reset
REQ-032 SHALL, while reset=0, asynchronously set:
- state IDLE
- seg[0]=(16,12), seg[1]=(15,12), seg[2]=(14,12); remaining segments (0,0)
- length=3, current and pending direction right
- eaten=0, game_over=0, snake_on=0, head_on=0, pixel pipeline cleared
REQ-033 SHALL restart from these values when reset is asserted mid-game, including in DEAD.

Verification
REQ-034 SHALL cover: reset release, right held, 3 ticks -> head (19,12), length 3, game_over 0.
REQ-035 SHALL cover: in RUN moving right, press left then tick -> left ignored, head x+1.
REQ-036 SHALL cover: food at (17,12), start, 1 tick -> eaten pulse 1 clk, length 4, tail (14,12) retained.
REQ-037 SHALL cover: press up, 13 ticks from y=12 -> 13th tick enters DEAD, game_over 1, head stays (16,0), later ticks ignored.
REQ-038 SHALL cover: pix=(330,245) -> head_on=1 and snake_on=1 exactly 2 clk later; pix=(700,10) -> both 0.
REQ-039 SHALL cover: length 5 in a tight loop, up/left/down sequence into the body -> DEAD; a move into the vacating tail cell -> no death.
